// File: rtl/cbus_mst_pkg.sv
// -----------------------------------------------------------------------------
// cbus_mst_pkg
// Shared CBUS definitions: direction encodings, master FSM state type, the
// default read-data pattern returned on a timed-out transaction, and the
// saturating increment used by the timeout counter.
// -----------------------------------------------------------------------------
package cbus_mst_pkg;

   // CBUS direction encoding, shared with the arbiter and slave register blocks
   localparam logic CBUS_RW_WR = 1'b1;
   localparam logic CBUS_RW_RD = 1'b0;

   // Default read data reported for a transaction that timed out
   localparam logic [31:0] CBUS_ERR_DATA_DEF = 32'hDEAD_BEEF;

   // Width of the timeout event counter
   localparam int unsigned TMO_CNT_W = 8;

   // Master FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } cbus_state_e;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [TMO_CNT_W-1:0] sat_inc(input logic [TMO_CNT_W-1:0] val);
      logic [TMO_CNT_W-1:0] res;
      if (val == {TMO_CNT_W{1'b1}}) begin
         res = val;
      end else begin
         res = val + {{(TMO_CNT_W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

endpackage

// File: rtl/cbus_mst.sv
// -----------------------------------------------------------------------------
// cbus_mst
// Single upstream CBUS initiator. Takes one host command over a valid/ready
// handshake, drives it onto CBUS as a level request, waits for a one-cycle ack
// or for the timeout to expire, then returns one response over valid/ready.
// Only one transaction is ever outstanding; the timeout guarantees the request
// line can never hang high.
//
// Ports
//   i_clk_sys, i_rst_sys_n          clock, asynchronous active-low reset
//   i_cmd_vld/o_cmd_rdy             host command handshake
//   i_cmd_rw/addr/wdata             host command payload (rw: 1=write)
//   o_rsp_vld/i_rsp_rdy             response handshake
//   o_rsp_rdata/o_rsp_err           response payload (err: 1=timeout)
//   o_cbus_req/rw/addr/wdata        CBUS request side
//   i_cbus_ack/i_cbus_rdata         CBUS completion side (ack is a pulse)
//   o_tmo_cnt                       saturating count of timeouts since reset
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module cbus_mst
   import cbus_mst_pkg::*;
#(
   parameter int unsigned ADDR_W   = 20,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = CBUS_ERR_DATA_DEF
) (
   input  logic                 i_clk_sys,
   input  logic                 i_rst_sys_n,
   input  logic                 i_cmd_vld,
   output logic                 o_cmd_rdy,
   input  logic                 i_cmd_rw,
   input  logic [ADDR_W-1:0]    i_cmd_addr,
   input  logic [DATA_W-1:0]    i_cmd_wdata,
   output logic                 o_rsp_vld,
   input  logic                 i_rsp_rdy,
   output logic [DATA_W-1:0]    o_rsp_rdata,
   output logic                 o_rsp_err,
   output logic                 o_cbus_req,
   output logic                 o_cbus_rw,
   input  logic                 i_cbus_ack,
   output logic [ADDR_W-1:0]    o_cbus_addr,
   output logic [DATA_W-1:0]    o_cbus_wdata,
   input  logic [DATA_W-1:0]    i_cbus_rdata,
   output logic [TMO_CNT_W-1:0] o_tmo_cnt
);

   localparam int unsigned       TMR_W     = $clog2(TIMEOUT + 1);
   // Timer value seen on the last permitted request cycle: req is high for
   // exactly TIMEOUT cycles because the timer starts at 0 on the first one.
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
   localparam logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_DATA);

   cbus_state_e          state_q,   state_d;
   logic                 cmd_rdy_q, cmd_rdy_d;
   logic                 req_q,     req_d;
   logic                 rw_q,      rw_d;
   logic [ADDR_W-1:0]    addr_q,    addr_d;
   logic [DATA_W-1:0]    wdata_q,   wdata_d;
   logic [TMR_W-1:0]     timer_q,   timer_d;
   logic                 rsp_vld_q, rsp_vld_d;
   logic [DATA_W-1:0]    rdata_q,   rdata_d;
   logic                 err_q,     err_d;
   logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // Next-state and next-output logic for the IDLE -> REQ -> RSP cycle
   always_comb begin
      state_d   = state_q;
      cmd_rdy_d = cmd_rdy_q;
      req_d     = req_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      timer_d   = timer_q;
      rsp_vld_d = rsp_vld_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      tmo_cnt_d = tmo_cnt_q;

      case (state_q)
         ST_IDLE: begin
            // Ready rises one cycle after reset release or response handoff
            cmd_rdy_d = 1'b1;
            if (i_cmd_vld && cmd_rdy_q) begin
               state_d   = ST_REQ;
               cmd_rdy_d = 1'b0;
               req_d     = 1'b1;
               rw_d      = i_cmd_rw;
               addr_d    = i_cmd_addr;
               wdata_d   = i_cmd_wdata;
               timer_d   = {TMR_W{1'b0}};
            end else begin
               state_d   = ST_IDLE;
            end
         end

         ST_REQ: begin
            // An ack on the final timer cycle still completes normally
            if (i_cbus_ack) begin
               state_d   = ST_RSP;
               req_d     = 1'b0;
               rsp_vld_d = 1'b1;
               err_d     = 1'b0;
               rdata_d   = (rw_q == CBUS_RW_WR) ? {DATA_W{1'b0}} : i_cbus_rdata;
            end else if (timer_q == TMR_LAST) begin
               state_d   = ST_RSP;
               req_d     = 1'b0;
               rsp_vld_d = 1'b1;
               err_d     = 1'b1;
               rdata_d   = ERR_RDATA;
               tmo_cnt_d = sat_inc(tmo_cnt_q);
            end else begin
               timer_d   = timer_q + TMR_W'(1'b1);
            end
         end

         ST_RSP: begin
            if (i_rsp_rdy) begin
               state_d   = ST_IDLE;
               rsp_vld_d = 1'b0;
               cmd_rdy_d = 1'b1;
            end else begin
               state_d   = ST_RSP;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            cmd_rdy_d = 1'b0;
            req_d     = 1'b0;
            rsp_vld_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops the request immediately
   always_ff @(posedge i_clk_sys or negedge i_rst_sys_n) begin
      if (!i_rst_sys_n) begin
         state_q   <= ST_IDLE;
         cmd_rdy_q <= 1'b0;
         req_q     <= 1'b0;
         rw_q      <= 1'b0;
         addr_q    <= {ADDR_W{1'b0}};
         wdata_q   <= {DATA_W{1'b0}};
         timer_q   <= {TMR_W{1'b0}};
         rsp_vld_q <= 1'b0;
         rdata_q   <= {DATA_W{1'b0}};
         err_q     <= 1'b0;
         tmo_cnt_q <= {TMO_CNT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         cmd_rdy_q <= cmd_rdy_d;
         req_q     <= req_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         timer_q   <= timer_d;
         rsp_vld_q <= rsp_vld_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   assign o_cmd_rdy    = cmd_rdy_q;
   assign o_cbus_req   = req_q;
   assign o_cbus_rw    = rw_q;
   assign o_cbus_addr  = addr_q;
   assign o_cbus_wdata = wdata_q;
   assign o_rsp_vld    = rsp_vld_q;
   assign o_rsp_rdata  = rdata_q;
   assign o_rsp_err    = err_q;
   assign o_tmo_cnt    = tmo_cnt_q;

endmodule

// File: tb/tb_cbus_mst.sv
// -----------------------------------------------------------------------------
// tb_cbus_mst
// Directed bench for cbus_mst with TIMEOUT=8. A table of transactions (command,
// ack cycle, response back-pressure, expected response) is replayed in a loop,
// followed by a hand-written reset-during-request sequence.
// -----------------------------------------------------------------------------
module tb_cbus_mst;

   localparam int unsigned ADDR_W  = 20;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned TIMEOUT = 8;

   logic              clk;
   logic              rst_n;
   logic              cmd_vld;
   logic              cmd_rdy;
   logic              cmd_rw;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_vld;
   logic              rsp_rdy;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              cbus_req;
   logic              cbus_rw;
   logic              cbus_ack;
   logic [ADDR_W-1:0] cbus_addr;
   logic [DATA_W-1:0] cbus_wdata;
   logic [DATA_W-1:0] cbus_rdata;
   logic [7:0]        tmo_cnt;

   int n_vec;
   int n_err;

   cbus_mst #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT),
      .ERR_DATA(32'hDEAD_BEEF)
   ) dut (
      .i_clk_sys   (clk),
      .i_rst_sys_n (rst_n),
      .i_cmd_vld   (cmd_vld),
      .o_cmd_rdy   (cmd_rdy),
      .i_cmd_rw    (cmd_rw),
      .i_cmd_addr  (cmd_addr),
      .i_cmd_wdata (cmd_wdata),
      .o_rsp_vld   (rsp_vld),
      .i_rsp_rdy   (rsp_rdy),
      .o_rsp_rdata (rsp_rdata),
      .o_rsp_err   (rsp_err),
      .o_cbus_req  (cbus_req),
      .o_cbus_rw   (cbus_rw),
      .i_cbus_ack  (cbus_ack),
      .o_cbus_addr (cbus_addr),
      .o_cbus_wdata(cbus_wdata),
      .i_cbus_rdata(cbus_rdata),
      .o_tmo_cnt   (tmo_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      int                ack_at;     // req cycle (1-based) carrying ack, 0 = never
      logic [DATA_W-1:0] ack_rdata;
      int                rdy_delay;  // cycles rsp_rdy held low
      bit                late_ack;   // pulse stray acks in RSP and IDLE
      logic [DATA_W-1:0] exp_rdata;
      logic              exp_err;
      int                exp_req;    // expected number of req-high cycles
      logic [7:0]        exp_tmo;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // advance one clock and settle just after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int guard;
      int req_cycles;
      guard = 0;
      while (cmd_rdy !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      chk($sformatf("v%0d_cmd_rdy_wait", idx), {31'd0, cmd_rdy}, 32'd1);

      cmd_vld   = 1'b1;
      cmd_rw    = v.rw;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      tick();
      cmd_vld   = 1'b0;
      cmd_addr  = 20'h0_0000;
      cmd_wdata = 32'h0000_0000;
      chk($sformatf("v%0d_req_rise", idx), {31'd0, cbus_req}, 32'd1);
      chk($sformatf("v%0d_cmd_rdy_low", idx), {31'd0, cmd_rdy}, 32'd0);

      req_cycles = 0;
      while (cbus_req === 1'b1 && req_cycles < 40) begin
         req_cycles++;
         chk($sformatf("v%0d_addr_c%0d", idx, req_cycles), {12'd0, cbus_addr}, {12'd0, v.addr});
         chk($sformatf("v%0d_wdata_c%0d", idx, req_cycles), cbus_wdata, v.wdata);
         chk($sformatf("v%0d_rw_c%0d", idx, req_cycles), {31'd0, cbus_rw}, {31'd0, v.rw});
         cbus_ack   = (v.ack_at == req_cycles) ? 1'b1 : 1'b0;
         cbus_rdata = v.ack_rdata;
         tick();
         cbus_ack   = 1'b0;
         cbus_rdata = 32'h0000_0000;
      end
      chk($sformatf("v%0d_req_cycles", idx), 32'(req_cycles), 32'(v.exp_req));
      chk($sformatf("v%0d_rsp_vld", idx), {31'd0, rsp_vld}, 32'd1);

      for (int i = 0; i < v.rdy_delay; i++) begin
         cbus_ack   = (v.late_ack && i == 0) ? 1'b1 : 1'b0;
         cbus_rdata = 32'h5555_AAAA;
         tick();
         cbus_ack   = 1'b0;
         chk($sformatf("v%0d_hold_vld_%0d", idx, i), {31'd0, rsp_vld}, 32'd1);
         chk($sformatf("v%0d_hold_rdata_%0d", idx, i), rsp_rdata, v.exp_rdata);
         chk($sformatf("v%0d_hold_err_%0d", idx, i), {31'd0, rsp_err}, {31'd0, v.exp_err});
         chk($sformatf("v%0d_hold_cmdrdy_%0d", idx, i), {31'd0, cmd_rdy}, 32'd0);
         chk($sformatf("v%0d_hold_req_%0d", idx, i), {31'd0, cbus_req}, 32'd0);
      end

      chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d_err", idx), {31'd0, rsp_err}, {31'd0, v.exp_err});
      chk($sformatf("v%0d_tmo_cnt", idx), {24'd0, tmo_cnt}, {24'd0, v.exp_tmo});

      rsp_rdy = 1'b1;
      tick();
      rsp_rdy = 1'b0;
      chk($sformatf("v%0d_rsp_done", idx), {31'd0, rsp_vld}, 32'd0);
      chk($sformatf("v%0d_back_idle", idx), {31'd0, cmd_rdy}, 32'd1);

      if (v.late_ack) begin
         cbus_ack = 1'b1;
         tick();
         cbus_ack = 1'b0;
         chk($sformatf("v%0d_stray_req", idx), {31'd0, cbus_req}, 32'd0);
         chk($sformatf("v%0d_stray_vld", idx), {31'd0, rsp_vld}, 32'd0);
         chk($sformatf("v%0d_stray_rdy", idx), {31'd0, cmd_rdy}, 32'd1);
         chk($sformatf("v%0d_stray_tmo", idx), {24'd0, tmo_cnt}, {24'd0, v.exp_tmo});
      end
   endtask

   initial begin
      vec_t fresh;
      n_vec = 0;
      n_err = 0;
      rst_n      = 1'b0;
      cmd_vld    = 1'b0;
      cmd_rw     = 1'b0;
      cmd_addr   = 20'h0_0000;
      cmd_wdata  = 32'h0000_0000;
      rsp_rdy    = 1'b0;
      cbus_ack   = 1'b0;
      cbus_rdata = 32'h0000_0000;

      //           rw    addr        wdata         ack rdata         dly late exp_rdata     err  req tmo
      vecs[0] = '{1'b1, 20'h00404, 32'h1234_5678, 3, 32'hFFFF_0000, 0, 1'b0, 32'h0000_0000, 1'b0, 3, 8'd0};
      vecs[1] = '{1'b0, 20'h00C10, 32'h0000_0000, 1, 32'hA5A5_0001, 0, 1'b0, 32'hA5A5_0001, 1'b0, 1, 8'd0};
      vecs[2] = '{1'b0, 20'h00020, 32'h0000_0000, 0, 32'h1111_1111, 2, 1'b1, 32'hDEAD_BEEF, 1'b1, 8, 8'd1};
      vecs[3] = '{1'b0, 20'h00024, 32'h0000_0000, 8, 32'h0BAD_F00D, 0, 1'b0, 32'h0BAD_F00D, 1'b0, 8, 8'd1};
      vecs[4] = '{1'b1, 20'hFFFFF, 32'hCAFE_0003, 2, 32'h9999_9999, 5, 1'b0, 32'h0000_0000, 1'b0, 2, 8'd1};
      vecs[5] = '{1'b1, 20'h00030, 32'h0F0F_0F0F, 0, 32'h2222_2222, 1, 1'b0, 32'hDEAD_BEEF, 1'b1, 8, 8'd2};
      vecs[6] = '{1'b0, 20'h80001, 32'h0000_0000, 7, 32'h7654_3210, 0, 1'b0, 32'h7654_3210, 1'b0, 7, 8'd2};

      #12;
      chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
      chk("rst_req", {31'd0, cbus_req}, 32'd0);
      chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
      chk("rst_tmo_cnt", {24'd0, tmo_cnt}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("post_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

      for (int k = 0; k < 7; k++) begin
         run_vec(vecs[k], k);
      end

      // reset while a request is outstanding
      cmd_vld   = 1'b1;
      cmd_rw    = 1'b1;
      cmd_addr  = 20'h00ABC;
      cmd_wdata = 32'h3333_4444;
      tick();
      cmd_vld   = 1'b0;
      chk("mid_req_up", {31'd0, cbus_req}, 32'd1);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, cbus_req}, 32'd0);
      chk("mid_rst_addr", {12'd0, cbus_addr}, 32'd0);
      chk("mid_rst_wdata", cbus_wdata, 32'd0);
      chk("mid_rst_rw", {31'd0, cbus_rw}, 32'd0);
      chk("mid_rst_tmo", {24'd0, tmo_cnt}, 32'd0);
      chk("mid_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
      chk("mid_rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      fresh = '{1'b1, 20'h00404, 32'h1234_5678, 2, 32'hFFFF_FFFF, 0, 1'b0, 32'h0000_0000, 1'b0, 2, 8'd0};
      run_vec(fresh, 7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
